// File: rtl/core_pkg.sv
// Shared constants, FSM state encoding and data-memory request payload for the mini core.
package core_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned MADDR_W         = 8;
  localparam int unsigned RADDR_W         = 6;
  localparam int unsigned ACK_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } mem_state_t;

  // Payload presented on the data-memory port for the duration of one access.
  typedef struct packed {
    logic               we;
    logic [MADDR_W-1:0] addr;
    logic [DATA_W-1:0]  wdata;
  } mem_req_t;

  // The memory address is the low MADDR_W bits of the ALU result.
  function automatic logic [MADDR_W-1:0] to_maddr(input logic [DATA_W-1:0] alu);
    return alu[MADDR_W-1:0];
  endfunction

endpackage

// File: rtl/dmem_req_ctrl.sv
// Data-memory request/ack handshake with ack timeout.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         launch an access with req_i (stage FSM leaving IDLE)
//   active_i        stage FSM is in REQ or WAIT (ack is only honoured here)
//   in_wait_i       stage FSM is in WAIT (timeout counter runs here)
//   req_i           request payload latched on start_i
//   dmem_ack_i      memory completion pulse
//   dmem_rdata_i    load data, valid with dmem_ack_i
//   dmem_req_o      request valid (registered)
//   dmem_we_o       write request (registered)
//   dmem_addr_o     memory address (registered)
//   dmem_wdata_o    store data (registered)
//   done_c          access completed this cycle
//   err_c           ack timeout reached this cycle
//   rdata_c         load data forwarded to the stage
module dmem_req_ctrl
  import core_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               active_i,
  input  logic               in_wait_i,
  input  mem_req_t           req_i,
  input  logic               dmem_ack_i,
  input  logic [DATA_W-1:0]  dmem_rdata_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [MADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0]  dmem_wdata_o,
  output logic               done_c,
  output logic               err_c,
  output logic [DATA_W-1:0]  rdata_c
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  mem_req_t         req_q, req_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // Handshake completion, timeout detection and request payload update.
  always_comb begin
    cnt_inc = cnt_q + CNT_W'(1);
    done_c  = active_i && dmem_ack_i;
    // An ack arriving on the final WAIT cycle still completes the access.
    err_c   = in_wait_i && !dmem_ack_i && (cnt_inc == CNT_W'(ACK_TIMEOUT));
    rdata_c = dmem_rdata_i;

    req_d = req_q;
    vld_d = vld_q;
    cnt_d = '0;

    if (start_i) begin
      req_d = req_i;
      vld_d = 1'b1;
    end else if (done_c || err_c) begin
      vld_d    = 1'b0;
      req_d.we = 1'b0;
    end

    if (in_wait_i && !done_c && !err_c) begin
      cnt_d = cnt_inc;
    end
  end

  // Request registers; reset drops any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      req_q <= req_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign dmem_req_o   = vld_q;
  assign dmem_we_o    = req_q.we;
  assign dmem_addr_o  = req_q.addr;
  assign dmem_wdata_o = req_q.wdata;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: performs data-memory loads/stores and drives the register-file write port.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   halted           halt flag from the EX/MEM register
//   data_rw          instruction is a memory op
//   data_mem_write   with data_rw: 1 = store, 0 = load
//   alu_output       ALU result / memory address
//   store_data       store operand
//   write_addr       destination register
//   dmem_*           data-memory request/ack port
//   rf_we/waddr/wdata register-file write port (registered, one-cycle pulse)
//   freeze_out       combinational stall to upstream while a memory access is pending
//   halted_out       sticky halt flag
//   mem_err          sticky ack-timeout flag
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halted,
  input  logic               data_rw,
  input  logic               data_mem_write,
  input  logic [DATA_W-1:0]  alu_output,
  input  logic [DATA_W-1:0]  store_data,
  input  logic [RADDR_W-1:0] write_addr,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [MADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               freeze_out,
  output logic               halted_out,
  output logic               mem_err
);

  mem_state_t         state_q, state_d;
  logic               rf_we_q, rf_we_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
  logic               halted_q, halted_d;
  logic               mem_err_q, mem_err_d;
  logic [RADDR_W-1:0] dest_q, dest_d;
  logic               is_load_q, is_load_d;

  logic               start_c;
  logic               done_c;
  logic               err_c;
  logic [DATA_W-1:0]  rdata_c;
  mem_req_t           new_req_c;

  assign new_req_c = '{we: data_mem_write, addr: to_maddr(alu_output), wdata: store_data};

  dmem_req_ctrl #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_dmem_req_ctrl (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_c),
    .active_i     ((state_q == REQ) || (state_q == WAIT)),
    .in_wait_i    (state_q == WAIT),
    .req_i        (new_req_c),
    .dmem_ack_i   (dmem_ack),
    .dmem_rdata_i (dmem_rdata),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .done_c       (done_c),
    .err_c        (err_c),
    .rdata_c      (rdata_c)
  );

  // Next-state and write-back logic.
  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    halted_d   = halted_q;
    mem_err_d  = mem_err_q;
    dest_d     = dest_q;
    is_load_d  = is_load_q;
    start_c    = 1'b0;

    case (state_q)
      IDLE: begin
        // Once halted, the stage ignores everything until reset.
        if (!halted_q) begin
          if (halted) begin
            halted_d = 1'b1;
          end else if (data_rw) begin
            start_c   = 1'b1;
            dest_d    = write_addr;
            is_load_d = !data_mem_write;
            state_d   = REQ;
          end else begin
            rf_we_d    = 1'b1;
            rf_waddr_d = write_addr;
            rf_wdata_d = alu_output;
          end
        end
      end
      REQ, WAIT: begin
        // An ack seen already in REQ is handled exactly like an ack in WAIT.
        if (done_c) begin
          if (is_load_q) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = dest_q;
            rf_wdata_d = rdata_c;
            state_d    = WB;
          end else begin
            state_d = IDLE;
          end
        end else if (err_c) begin
          mem_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      halted_q   <= 1'b0;
      mem_err_q  <= 1'b0;
      dest_q     <= '0;
      is_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      halted_q   <= halted_d;
      mem_err_q  <= mem_err_d;
      dest_q     <= dest_d;
      is_load_q  <= is_load_d;
    end
  end

  // Stall upstream from the cycle a memory op is accepted until write-back.
  assign freeze_out = start_c || (state_q == REQ) || (state_q == WAIT);

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign halted_out = halted_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
module tb_mem_wb_stage;
  import core_pkg::*;

  logic               clk;
  logic               rst;
  logic               halted;
  logic               data_rw;
  logic               data_mem_write;
  logic [DATA_W-1:0]  alu_output;
  logic [DATA_W-1:0]  store_data;
  logic [RADDR_W-1:0] write_addr;
  logic               dmem_req;
  logic               dmem_we;
  logic [MADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               freeze_out;
  logic               halted_out;
  logic               mem_err;

  int n_run;
  int n_fail;

  mem_wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .halted         (halted),
    .data_rw        (data_rw),
    .data_mem_write (data_mem_write),
    .alu_output     (alu_output),
    .store_data     (store_data),
    .write_addr     (write_addr),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .freeze_out     (freeze_out),
    .halted_out     (halted_out),
    .mem_err        (mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DATA_W-1:0]  alu_v [3];
  logic [RADDR_W-1:0] dst_v [3];

  initial begin
    n_run  = 0;
    n_fail = 0;
    alu_v  = '{8'h11, 8'h22, 8'h33};
    dst_v  = '{6'd5, 6'd6, 6'd7};

    rst = 1'b1; halted = 1'b0; data_rw = 1'b0; data_mem_write = 1'b0;
    alu_output = '0; store_data = '0; write_addr = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    tick();
    tick();
    chk("rst rf_we",      32'(rf_we), 32'd0);
    chk("rst dmem_req",   32'(dmem_req), 32'd0);
    chk("rst freeze",     32'(freeze_out), 32'd0);
    chk("rst halted_out", 32'(halted_out), 32'd0);
    chk("rst mem_err",    32'(mem_err), 32'd0);
    chk("rst rf_wdata",   32'(rf_wdata), 32'd0);

    // Three back-to-back ALU ops.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_output = alu_v[i];
      write_addr = dst_v[i];
      #1;
      chk("alu freeze", 32'(freeze_out), 32'd0);
      tick();
      chk("alu rf_we",    32'(rf_we), 32'd1);
      chk("alu rf_waddr", 32'(rf_waddr), 32'(dst_v[i]));
      chk("alu rf_wdata", 32'(rf_wdata), 32'(alu_v[i]));
      chk("alu freeze2",  32'(freeze_out), 32'd0);
    end

    // Load from 0x40 into r9, ack on the fourth request cycle.
    data_rw = 1'b1; data_mem_write = 1'b0; alu_output = 8'h40; write_addr = 6'd9;
    #1;
    chk("ld freeze c0", 32'(freeze_out), 32'd1);
    chk("ld req c0",    32'(dmem_req), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("ld req",    32'(dmem_req), 32'd1);
      chk("ld addr",   32'(dmem_addr), 32'h40);
      chk("ld we",     32'(dmem_we), 32'd0);
      chk("ld freeze", 32'(freeze_out), 32'd1);
      chk("ld rf_we",  32'(rf_we), 32'd0);
      if (i == 4) begin
        dmem_ack = 1'b1; dmem_rdata = 8'hA5;
      end
    end
    tick();
    chk("ld wb rf_we",    32'(rf_we), 32'd1);
    chk("ld wb rf_waddr", 32'(rf_waddr), 32'd9);
    chk("ld wb rf_wdata", 32'(rf_wdata), 32'hA5);
    chk("ld wb req",      32'(dmem_req), 32'd0);
    chk("ld wb freeze",   32'(freeze_out), 32'd0);
    dmem_ack = 1'b0; dmem_rdata = '0;
    data_rw = 1'b0; alu_output = 8'h55; write_addr = 6'd3;
    tick();
    chk("ld post rf_we", 32'(rf_we), 32'd0);
    tick();
    chk("ld next alu rf_we",    32'(rf_we), 32'd1);
    chk("ld next alu rf_wdata", 32'(rf_wdata), 32'h55);
    chk("ld next alu rf_waddr", 32'(rf_waddr), 32'd3);

    // Store 0x3C to 0x80, ack in the REQ cycle.
    data_rw = 1'b1; data_mem_write = 1'b1; alu_output = 8'h80; store_data = 8'h3C; write_addr = 6'd2;
    tick();
    chk("st req",    32'(dmem_req), 32'd1);
    chk("st we",     32'(dmem_we), 32'd1);
    chk("st addr",   32'(dmem_addr), 32'h80);
    chk("st wdata",  32'(dmem_wdata), 32'h3C);
    chk("st freeze", 32'(freeze_out), 32'd1);
    chk("st rf_we",  32'(rf_we), 32'd0);
    dmem_ack = 1'b1; data_rw = 1'b0; data_mem_write = 1'b0;
    tick();
    chk("st done req",    32'(dmem_req), 32'd0);
    chk("st done we",     32'(dmem_we), 32'd0);
    chk("st done rf_we",  32'(rf_we), 32'd0);
    chk("st done freeze", 32'(freeze_out), 32'd0);
    dmem_ack = 1'b0;

    // Load that is never acknowledged: REQ plus 15 WAIT cycles, then error.
    data_rw = 1'b1; data_mem_write = 1'b0; alu_output = 8'h20; write_addr = 6'd4;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("to req",     32'(dmem_req), 32'd1);
      chk("to err",     32'(mem_err), 32'd0);
      chk("to freeze",  32'(freeze_out), 32'd1);
    end
    data_rw = 1'b0;
    tick();
    chk("to mem_err", 32'(mem_err), 32'd1);
    chk("to req off", 32'(dmem_req), 32'd0);
    chk("to rf_we",   32'(rf_we), 32'd0);
    chk("to freeze2", 32'(freeze_out), 32'd0);
    tick();
    tick();
    chk("to sticky", 32'(mem_err), 32'd1);

    // Reset in the middle of WAIT with a simultaneous ack.
    data_rw = 1'b1; alu_output = 8'h10; write_addr = 6'd1;
    tick();
    tick();
    tick();
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 8'hFF; data_rw = 1'b0;
    tick();
    chk("mrst rf_we",      32'(rf_we), 32'd0);
    chk("mrst req",        32'(dmem_req), 32'd0);
    chk("mrst we",         32'(dmem_we), 32'd0);
    chk("mrst mem_err",    32'(mem_err), 32'd0);
    chk("mrst halted_out", 32'(halted_out), 32'd0);
    chk("mrst freeze",     32'(freeze_out), 32'd0);
    chk("mrst rf_wdata",   32'(rf_wdata), 32'd0);
    chk("mrst rf_waddr",   32'(rf_waddr), 32'd0);
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    tick();
    chk("mrst idle rf_we",    32'(rf_we), 32'd1);
    chk("mrst idle rf_wdata", 32'(rf_wdata), 32'h10);
    chk("mrst idle req",      32'(dmem_req), 32'd0);

    // Halt on a memory op: no access, later ops ignored until reset.
    halted = 1'b1; data_rw = 1'b1; alu_output = 8'h99; write_addr = 6'd8;
    #1;
    chk("hlt freeze c0", 32'(freeze_out), 32'd0);
    tick();
    chk("hlt halted_out", 32'(halted_out), 32'd1);
    chk("hlt req",        32'(dmem_req), 32'd0);
    chk("hlt rf_we",      32'(rf_we), 32'd0);
    halted = 1'b0; data_rw = 1'b0; alu_output = 8'h77;
    tick();
    tick();
    chk("hlt ignore rf_we", 32'(rf_we), 32'd0);
    chk("hlt sticky",       32'(halted_out), 32'd1);
    data_rw = 1'b1;
    #1;
    chk("hlt mem freeze", 32'(freeze_out), 32'd0);
    tick();
    chk("hlt mem req", 32'(dmem_req), 32'd0);
    rst = 1'b1; data_rw = 1'b0;
    tick();
    chk("hlt rst halted_out", 32'(halted_out), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("hlt resume rf_we",    32'(rf_we), 32'd1);
    chk("hlt resume rf_wdata", 32'(rf_wdata), 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
